// File: rtl/lru_access_ctrl.sv
// Access sequencer for the per-set LRU buffer: lookup, victim selection, refill
// handshake, one LRU write per successful access, response and hit/miss statistics.
module lru_access_ctrl #(
    parameter int WAYS        = 8,
    parameter int SET_W       = 7,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic [WAYS-1:0]  req_hit_vec,
    output logic [SET_W-1:0] lru_addr,
    output logic             lru_we,
    output logic             lru_hit_sig,
    output logic [WAYS-1:0]  lru_hit_way,
    input  logic [WAYS-1:0]  lru_flag,
    output logic             refill_req,
    output logic [WAYS-1:0]  refill_way,
    output logic [SET_W-1:0] refill_set,
    input  logic             refill_ack,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WAYS-1:0]  resp_way,
    output logic             resp_hit,
    output logic             resp_err,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_UPDATE,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [WAYS-1:0]    hv_q, hv_d;
    logic [WAYS-1:0]    victim_q, victim_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [WAYS-1:0]    resp_way_q, resp_way_d;
    logic               resp_hit_q, resp_hit_d;
    logic               resp_err_q, resp_err_d;

    logic [WAYS-1:0]    flag_low;
    logic               hv_multi;
    logic               hv_any;

    // Isolate the lowest set bit of the LRU flag; two's-complement trick.
    assign flag_low = lru_flag & (~lru_flag + WAYS'(1));
    assign hv_multi = |(hv_q & (hv_q - WAYS'(1)));
    assign hv_any   = |hv_q;

    assign lru_addr = set_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            set_q      <= '0;
            hv_q       <= '0;
            victim_q   <= '0;
            tmo_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            resp_way_q <= '0;
            resp_hit_q <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_q      <= set_d;
            hv_q       <= hv_d;
            victim_q   <= victim_d;
            tmo_q      <= tmo_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            resp_way_q <= resp_way_d;
            resp_hit_q <= resp_hit_d;
            resp_err_q <= resp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        hv_d        = hv_q;
        victim_d    = victim_q;
        tmo_d       = tmo_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        resp_way_d  = resp_way_q;
        resp_hit_d  = resp_hit_q;
        resp_err_d  = resp_err_q;

        req_ready   = 1'b0;
        lru_we      = 1'b0;
        lru_hit_sig = 1'b0;
        lru_hit_way = '0;
        refill_req  = 1'b0;
        refill_way  = '0;
        refill_set  = '0;
        resp_valid  = 1'b0;
        resp_way    = '0;
        resp_hit    = 1'b0;
        resp_err    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    set_d   = req_set;
                    hv_d    = req_hit_vec;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hv_multi) begin
                    resp_way_d = '0;
                    resp_hit_d = 1'b0;
                    resp_err_d = 1'b1;
                    state_d    = S_RESP;
                end else if (hv_any) begin
                    state_d = S_UPDATE;
                end else begin
                    victim_d = (flag_low == '0) ? WAYS'(1) : flag_low;
                    tmo_d    = '0;
                    state_d  = S_REFILL;
                end
            end
            S_REFILL: begin
                refill_req = 1'b1;
                refill_way = victim_q;
                refill_set = set_q;
                // Ack is tested first so a fill landing on the final cycle still completes.
                if (refill_ack) begin
                    state_d = S_UPDATE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    resp_way_d = '0;
                    resp_hit_d = 1'b0;
                    resp_err_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_UPDATE: begin
                lru_we      = 1'b1;
                lru_hit_sig = hv_any;
                lru_hit_way = hv_any ? hv_q : victim_q;
                resp_way_d  = hv_any ? hv_q : victim_q;
                resp_hit_d  = hv_any;
                resp_err_d  = 1'b0;
                if (hv_any) begin
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_way   = resp_way_q;
                resp_hit   = resp_hit_q;
                resp_err   = resp_err_q;
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
